// File: rtl/meikyuu_vga_pkg.sv
// Shared VGA timing constants for the meikyuu display path (640x480@60 defaults).
package meikyuu_vga_pkg;

  // Coordinate width shared with the sprite and maze renderers.
  localparam int unsigned VGA_CW = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Total positions on one axis: active, front porch, sync, back porch.
  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // First position of the sync pulse on one axis.
  function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
    return act + fp;
  endfunction

  // First position after the sync pulse on one axis.
  function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync);
    return act + fp + sync;
  endfunction

  localparam int unsigned VGA_H_TOTAL =
      axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int unsigned VGA_V_TOTAL =
      axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate prescaler: one-cycle registered strobe every CLK_DIV board clocks.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic pix_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q;

  // Wrapping divider count; with CLK_DIV=1 it stays at zero.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DivLast) div_d = '0;
  end

  // Strobe decoded from the next count so it is high exactly while div==CLK_DIV-1.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DivLast);
    end
  end

  assign pix_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position counters plus registered sync/active/strobe decode.
module vga_timing_gen
  import meikyuu_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CW       = VGA_CW
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic [CW-1:0] HLast      = CW'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CW-1:0] VLast      = CW'(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CW-1:0] HActive    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncStart = CW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] HSyncEnd   = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] VSyncStart = CW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] VSyncEnd   = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  // Next raster position: advance only on pixel ticks, wrapping at line and frame ends.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_tick) begin
      if (x_q == HLast) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Flags decoded from the next position so they register coherently with x/y.
  always_comb begin
    active_d      = (x_d < HActive) && (y_d < VActive);
    hsync_d       = ((x_d >= HSyncStart) && (x_d < HSyncEnd)) ? HS_POL : ~HS_POL;
    vsync_d       = ((y_d >= VSyncStart) && (y_d < VSyncEnd)) ? VS_POL : ~VS_POL;
    line_start_d  = pix_tick && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  // Output registers; reset parks at the last position so the first tick presents (0,0).
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      x_q           <= HLast;
      y_q           <= VLast;
      active_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing, a tiny CLK_DIV=1 raster, and CLK_DIV=4.
module tb_vga_timing_gen;

  logic clk;
  logic rst_a, rst_b, rst_c;

  logic       a_tick, a_hs, a_vs, a_act, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_hs, b_vs, b_act, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_tick, c_hs, c_vs, c_act, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  int n_pass  = 0;
  int n_total = 0;

  vga_timing_gen u_dut_a (
    .CLOCK_50 (clk), .reset (rst_a), .pix_tick (a_tick), .hsync (a_hs), .vsync (a_vs),
    .active (a_act), .x (a_x), .y (a_y), .line_start (a_ls), .frame_start (a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1), .CLK_DIV (1), .CW (10)
  ) u_dut_b (
    .CLOCK_50 (clk), .reset (rst_b), .pix_tick (b_tick), .hsync (b_hs), .vsync (b_vs),
    .active (b_act), .x (b_x), .y (b_y), .line_start (b_ls), .frame_start (b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0), .CLK_DIV (4), .CW (10)
  ) u_dut_c (
    .CLOCK_50 (clk), .reset (rst_c), .pix_tick (c_tick), .hsync (c_hs), .vsync (c_vs),
    .active (c_act), .x (c_x), .y (c_y), .line_start (c_ls), .frame_start (c_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Packs {x, y, active, hsync, vsync, line_start, frame_start} for one comparison.
  function automatic logic [31:0] pk(input int px, input int py, input bit act, input bit hs,
                                     input bit vs, input bit ls, input bit fs);
    return {7'd0, px[9:0], py[9:0], act, hs, vs, ls, fs};
  endfunction

  initial begin
    int hs_low, hs_min, hs_max, act_low, act_min, x_err, ls_extra, zero_ticks, cyc, p;
    bit found;
    logic [9:0] px, py;
    logic pa, ph, pv, pl, pf, pt;
    int viol, xchg, fs_cnt, org_cnt, tick_cnt;

    tbl[0]  = '{0,   0,  0, 1, 0, 0, 1, 1};
    tbl[1]  = '{1,   1,  0, 1, 0, 0, 0, 0};
    tbl[2]  = '{7,   7,  0, 1, 0, 0, 0, 0};
    tbl[3]  = '{8,   8,  0, 0, 0, 0, 0, 0};
    tbl[4]  = '{9,   9,  0, 0, 0, 0, 0, 0};
    tbl[5]  = '{10, 10,  0, 0, 1, 0, 0, 0};
    tbl[6]  = '{11, 11,  0, 0, 1, 0, 0, 0};
    tbl[7]  = '{12, 12,  0, 0, 0, 0, 0, 0};
    tbl[8]  = '{13, 13,  0, 0, 0, 0, 0, 0};
    tbl[9]  = '{14,  0,  1, 1, 0, 0, 1, 0};
    tbl[10] = '{56,  0,  4, 0, 0, 0, 1, 0};
    tbl[11] = '{70,  0,  5, 0, 0, 1, 1, 0};
    tbl[12] = '{83, 13,  5, 0, 0, 1, 0, 0};
    tbl[13] = '{84,  0,  6, 0, 0, 0, 1, 0};
    tbl[14] = '{97, 13,  6, 0, 0, 0, 0, 0};
    tbl[15] = '{98,  0,  0, 1, 0, 0, 1, 1};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (3) step();

    // Reset state of all three instances.
    check("a_reset", {a_tick, pk(a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs)},
          {1'b0, pk(799, 524, 0, 1, 1, 0, 0)});
    check("b_reset", {b_tick, pk(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs)},
          {1'b0, pk(13, 6, 0, 0, 0, 0, 0)});
    check("c_reset", {c_tick, pk(c_x, c_y, c_act, c_hs, c_vs, c_ls, c_fs)},
          {1'b0, pk(13, 6, 0, 1, 1, 0, 0)});

    // Default timing: first tick then (0,0).
    rst_a = 1'b1;
    step();
    check("a_edge1", {a_tick, pk(a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs)},
          {1'b1, pk(799, 524, 0, 1, 1, 0, 0)});
    step();
    check("a_origin", {a_tick, pk(a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs)},
          {1'b0, pk(0, 0, 1, 1, 1, 1, 1)});
    step();
    check("a_origin_2nd_cycle", {a_tick, pk(a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs)},
          {1'b1, pk(0, 0, 1, 1, 1, 0, 0)});

    // One full line, two board clocks per pixel.
    hs_low = 0; hs_min = 9999; hs_max = -1; act_low = 0; act_min = 9999;
    x_err = 0; ls_extra = 0;
    for (int i = 1; i < 800; i++) begin
      step();
      if (a_ls || a_fs) ls_extra++;
      if (int'(a_x) != i || a_y != 10'd0) x_err++;
      if (!a_hs) begin
        hs_low++;
        if (i < hs_min) hs_min = i;
        if (i > hs_max) hs_max = i;
      end
      if (!a_act) begin
        act_low++;
        if (i < act_min) act_min = i;
      end
      step();
      if (a_ls || a_fs) ls_extra++;
    end
    check("a_line_xseq_errors", x_err, 0);
    check("a_hs_low_count", hs_low, 96);
    check("a_hs_low_first", hs_min, 656);
    check("a_hs_low_last", hs_max, 751);
    check("a_act_low_count", act_low, 160);
    check("a_act_low_first", act_min, 640);
    check("a_ls_inside_line", ls_extra, 0);
    step();
    check("a_line1_start", pk(a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs),
          pk(0, 1, 1, 1, 1, 1, 0));

    // Tiny raster, CLK_DIV=1: table of positions p counted from the first presented pixel.
    rst_b = 1'b1;
    p = -2;
    zero_ticks = 0;
    for (int v = 0; v < 16; v++) begin
      while (p < tbl[v].p) begin
        step();
        p++;
        if (p >= -1 && !b_tick) zero_ticks++;
      end
      check($sformatf("b_vec_p%0d", tbl[v].p), pk(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs),
            pk(tbl[v].x, tbl[v].y, tbl[v].act, tbl[v].hs, tbl[v].vs, tbl[v].ls, tbl[v].fs));
    end
    check("b_tick_constant", zero_ticks, 0);

    // Frame period between frame_start pulses.
    cyc = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      cyc++;
      if (b_fs) found = 1;
    end
    check("b_frame_period", found ? cyc : -1, 98);

    // Asynchronous reset mid-frame at (5,3).
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (b_x == 10'd5 && b_y == 10'd3) found = 1;
    end
    check("b_reach_5_3", found, 1);
    #2 rst_b = 1'b0;
    #1;
    check("b_async_reset", {b_tick, pk(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs)},
          {1'b0, pk(13, 6, 0, 0, 0, 0, 0)});
    step();
    check("b_reset_held", pk(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs), pk(13, 6, 0, 0, 0, 0, 0));
    rst_b = 1'b1;
    step();
    check("b_rel_edge1", {b_tick, pk(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs)},
          {1'b1, pk(13, 6, 0, 0, 0, 0, 0)});
    step();
    check("b_rel_origin", pk(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs), pk(0, 0, 1, 0, 0, 1, 1));

    // CLK_DIV=4: outputs may only move on the edge that follows a pix_tick cycle.
    rst_c = 1'b1;
    px = c_x; py = c_y; pa = c_act; ph = c_hs; pv = c_vs; pl = c_ls; pf = c_fs; pt = c_tick;
    viol = 0; xchg = 0; fs_cnt = 0; org_cnt = 0; tick_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!pt && ({c_x, c_y, c_act, c_hs, c_vs} != {px, py, pa, ph, pv} || c_ls || c_fs))
        viol++;
      if (c_x != px) xchg++;
      if (c_fs) fs_cnt++;
      if (c_x == 10'd0 && c_y == 10'd0) org_cnt++;
      if (c_tick) tick_cnt++;
      px = c_x; py = c_y; pa = c_act; ph = c_hs; pv = c_vs; pl = c_ls; pf = c_fs; pt = c_tick;
    end
    check("c_change_without_tick", viol, 0);
    check("c_x_changes", xchg, 100);
    check("c_tick_count", tick_cnt, 100);
    check("c_fs_cycles", fs_cnt, 2);
    check("c_origin_cycles", org_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
